cp0_exc_ctrl: RTL
=================

Name: cp0_exc_ctrl

Overview:
- CP0 register file plus exception/ERET sequencer for the 5-stage MIPS pipeline.
- Takes the committed exception or ERET decision from the MEM-stage detector and updates Status, Cause, EPC and BadVAddr.
- Runs Count/Compare and samples the hardware interrupt lines.
- Then runs a flush/redirect handshake with the fetch stage, so that exactly one redirect is delivered per event.

Parameters:
- EXC_VECTOR, 32'hBFC00380, PC the fetch stage is redirected to on an exception.
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, EXL=0, IE=0).

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- exc_valid  in  1  MEM stage reports an exception this cycle.
- exc_code  in  5  ExcCode written to Cause[6:2].
- exc_bd  in  1  faulting instruction is in a delay slot.
- exc_epc  in  32  EPC value, already BD-corrected.
- exc_badv_we  in  1  BadVAddr is loaded on this exception.
- exc_badvaddr  in  32  faulting address.
- eret_valid  in  1  ERET committed this cycle.
- mtc0_we  in  1  MTC0 write strobe.
- c0_waddr  in  5  MTC0 target register number.
- c0_wdata  in  32  MTC0 data.
- c0_raddr  in  5  MFC0 source register number.
- c0_rdata  out  32  MFC0 read data, combinational.
- hw_int  in  6  external interrupt lines, level-sensitive.
- fetch_ready  in  1  fetch stage accepts the redirect.
- int_pending  out  1  interrupt request to the MEM-stage detector.
- flush  out  1  kill the IF..MEM stages.
- redirect_valid  out  1  redirect_pc is valid.
- redirect_pc  out  32  new fetch PC.
- status_exl  out  1  Status.EXL, for exception gating.
- busy  out  1  sequencer not IDLE; pipeline stalls while this is high.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - Status=STATUS_RST; Cause=0; EPC=0; BadVAddr=0; Count=0; Compare=0; tick=0.
  - state=IDLE.
  - flush=0, redirect_valid=0, redirect_pc=0, busy=0.
  - A reset during FLUSH or REDIR aborts the sequence and leaves no redirect pending.
- Register map: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14. Any other register reads 0; writes to it are ignored.
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0]. All other Status bits are read-only at their reset value.
  - Cause: IP[9:8] only.
  - BadVAddr: read-only to MTC0.
- Count:
  - tick toggles every cycle; Count increments when tick=1, i.e. one step per 2 cycles.
  - An MTC0 to Count overrides the increment in that cycle.
- Timer interrupt (Cause.TI, bit 30):
  - Set on the edge after Count==Compare while Compare!=0.
  - Cleared by any MTC0 to Compare; the clear wins over a set in the same cycle.
- Interrupt pending bits, registered each cycle:
  - Cause.IP[15:10] = {hw_int[5]|TI, hw_int[4:0]}.
  - int_pending = IE & ~EXL & |(Cause.IP[15:8] & Status.IM[15:8]), combinational from the registers.
- FSM, states IDLE, FLUSH, REDIR:
  - IDLE, exc_valid=1, at the edge:
    - EXL=1.
    - Cause.BD=exc_bd; Cause.ExcCode=exc_code.
    - EPC=exc_epc when EXL was 0; EPC unchanged when EXL was already 1.
    - BadVAddr=exc_badvaddr when exc_badv_we=1.
    - redirect_pc=EXC_VECTOR.
    - Next state FLUSH.
  - IDLE, eret_valid=1 (and exc_valid=0): EXL=0; redirect_pc=EPC; next state FLUSH.
  - FLUSH: flush=1, busy=1 for exactly one cycle; next state REDIR.
  - REDIR: redirect_valid=1, busy=1; redirect_pc held stable.
    - Leave to IDLE on the edge where fetch_ready=1.
    - Wait indefinitely while fetch_ready=0.
- Priority within one IDLE cycle: exc_valid > eret_valid > mtc0_we.
  - An MTC0 coincident with an exception or ERET is dropped.
  - An MTC0 to EPC or Status coincident with an accepted event is always dropped.
- While busy=1, exc_valid, eret_valid and mtc0_we are ignored; the pipeline is stalled and flushed, so no event is lost.
- Event-to-flush latency is 1 cycle; event-to-first-redirect_valid latency is 2 cycles.
- MFC0 returns the register's value before any same-cycle write; there is no internal bypass.

Decomposition:
- Shared package holds:
  - CP0 register numbers.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12.
  - Status/Cause bit positions.
  - FSM state encoding.
- One natural sub-module: cp0_timer. It holds Count, Compare, tick and TI, and outputs timer_int.

Test Plan:
- Reset check: after reset, read Status → 32'h00400000; read Cause, EPC and Count → 0; flush=0, redirect_valid=0.
- Overflow exception: exc_valid with code 12, exc_epc=32'hBFC00100, exc_bd=0.
  - Next cycle: flush=1.
  - Cycle after: redirect_valid=1, redirect_pc=32'hBFC00380.
  - Registers: EPC=32'hBFC00100, Cause[6:2]=12, Status.EXL=1.
- fetch_ready handshake: hold fetch_ready=0 for 3 cycles → redirect_valid and redirect_pc stay stable for those cycles. Assert fetch_ready=1 → IDLE one cycle later.
- ERET: with EPC=32'hBFC00200, pulse eret_valid → Status.EXL=0; redirect_pc=32'hBFC00200 two cycles later.
- Timer interrupt: write Compare=5 with IE=1 and IM7=1 → Cause bit 15 set and int_pending=1 about 10 cycles later. Then MTC0 Compare=0 → TI cleared on the next edge.
- Same-cycle conflict: exc_valid and an MTC0 to EPC with 32'h1234 in the same cycle → EPC=exc_epc and the MTC0 value is discarded. Then exc_valid again while busy → ignored, with no second flush.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, bit positions and sequencer states.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_IM  = 8;
    localparam int CAUSE_CODE = 2;
    localparam int CAUSE_IP   = 8;
    localparam int CAUSE_TI   = 30;
    localparam int CAUSE_BD   = 31;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_REDIR = 2'd2
    } exc_state_e;

endpackage

// File: rtl/cp0_exc_ctrl_timer.sv
// Count/Compare timer: Count advances once every two cycles, TI latches on a Count==Compare match.
module cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic tick;

    // A Compare write clears TI even if the match would set it in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick      <= 1'b0;
            count     <= 32'd0;
            compare   <= 32'd0;
            timer_int <= 1'b0;
        end else begin
            tick <= ~tick;
            if (count_we)
                count <= wdata;
            else if (tick)
                count <= count + 32'd1;
            if (compare_we) begin
                compare   <= wdata;
                timer_int <= 1'b0;
            end else if ((count == compare) && (compare != 32'd0)) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file with an exception/ERET sequencer that flushes the pipe and hands fetch one redirect.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic        exc_bd,
    input  logic [31:0] exc_epc,
    input  logic        exc_badv_we,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_valid,
    input  logic        mtc0_we,
    input  logic [4:0]  c0_waddr,
    input  logic [31:0] c0_wdata,
    input  logic [4:0]  c0_raddr,
    output logic [31:0] c0_rdata,
    input  logic [5:0]  hw_int,
    input  logic        fetch_ready,
    output logic        int_pending,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        status_exl,
    output logic        busy
);

    exc_state_e state;

    logic [7:0]  status_im;
    logic        status_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_code;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_int;

    logic        exc_take;
    logic        eret_take;
    logic        mtc0_take;
    logic [31:0] status_val;
    logic [31:0] cause_val;

    // Events are only accepted in IDLE; the pipeline is stalled otherwise.
    assign exc_take  = (state == S_IDLE) && exc_valid;
    assign eret_take = (state == S_IDLE) && eret_valid && !exc_valid;
    assign mtc0_take = (state == S_IDLE) && mtc0_we && !exc_valid && !eret_valid;

    assign status_val = {STATUS_RST[31:16], status_im, STATUS_RST[7:2], status_exl, status_ie};
    assign cause_val  = {cause_bd, timer_int, 14'd0, cause_ip_hw, cause_ip_sw, 1'b0, cause_code, 2'b00};

    assign int_pending = status_ie && !status_exl && |({cause_ip_hw, cause_ip_sw} & status_im);

    cp0_timer u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (mtc0_take && (c0_waddr == REG_COUNT)),
        .compare_we (mtc0_take && (c0_waddr == REG_COMPARE)),
        .wdata      (c0_wdata),
        .count      (count),
        .compare    (compare),
        .timer_int  (timer_int)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            status_im   <= STATUS_RST[15:8];
            status_exl  <= STATUS_RST[1];
            status_ie   <= STATUS_RST[0];
            cause_bd    <= 1'b0;
            cause_ip_hw <= 6'd0;
            cause_ip_sw <= 2'd0;
            cause_code  <= 5'd0;
            epc         <= 32'd0;
            badvaddr    <= 32'd0;
        end else begin
            cause_ip_hw <= {hw_int[5] | timer_int, hw_int[4:0]};
            if (exc_take) begin
                status_exl <= 1'b1;
                cause_bd   <= exc_bd;
                cause_code <= exc_code;
                // A nested exception keeps the original return address.
                if (!status_exl)
                    epc <= exc_epc;
                if (exc_badv_we)
                    badvaddr <= exc_badvaddr;
            end else if (eret_take) begin
                status_exl <= 1'b0;
            end else if (mtc0_take) begin
                case (c0_waddr)
                    REG_STATUS: begin
                        status_im  <= c0_wdata[15:8];
                        status_exl <= c0_wdata[STATUS_EXL];
                        status_ie  <= c0_wdata[STATUS_IE];
                    end
                    REG_CAUSE: cause_ip_sw <= c0_wdata[9:8];
                    REG_EPC:   epc         <= c0_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= S_IDLE;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            busy           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (exc_take || eret_take) begin
                        redirect_pc <= exc_take ? EXC_VECTOR : epc;
                        flush       <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    flush          <= 1'b0;
                    redirect_valid <= 1'b1;
                    state          <= S_REDIR;
                end
                S_REDIR: begin
                    if (fetch_ready) begin
                        redirect_valid <= 1'b0;
                        busy           <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                    busy           <= 1'b0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        c0_rdata = 32'd0;
        case (c0_raddr)
            REG_BADVADDR: c0_rdata = badvaddr;
            REG_COUNT:    c0_rdata = count;
            REG_COMPARE:  c0_rdata = compare;
            REG_STATUS:   c0_rdata = status_val;
            REG_CAUSE:    c0_rdata = cause_val;
            REG_EPC:      c0_rdata = epc;
            default:      c0_rdata = 32'd0;
        endcase
    end

endmodule
